// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single physical-memory port between the I-cache and the D-cache.
// Whole-line requests are serialized onto one memory interface. When both caches
// request in the same cycle, the grant alternates round-robin.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   icache_pmem_read/address    I-cache line read request (held until resp)
//   icache_pmem_rdata/resp      line and completion pulse back to the I-cache
//   dcache_pmem_read/write      D-cache fill / write-back request (write wins if both)
//   dcache_pmem_address/wdata   D-cache request address and write-back line
//   dcache_pmem_rdata/resp      line and completion pulse back to the D-cache
//   pmem_read/write/address     memory strobes and line-aligned address
//   pmem_wdata                  write-back line (zero unless serving the D-cache)
//   pmem_rdata/resp             memory read data and completion pulse
//   arb_busy                    high while a transaction is being served
module cache_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  arb_busy
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;
    typedef enum logic {GrantI, GrantD} grant_e;

    // Clears the word offset and byte select so memory always sees a line address.
    localparam logic [ADDR_WIDTH-1:0] LineMask =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d;

    logic i_req;
    logic d_req;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

    // Read data goes to both caches unconditionally; only the resp qualifies it.
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantI;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        arb_busy         = 1'b0;

        case (state_q)
            StIdle: begin
                // A pmem_resp seen here belongs to no one and is dropped.
                if (i_req && d_req) begin
                    if (last_grant_q == GrantI) begin
                        state_d      = StServeD;
                        last_grant_d = GrantD;
                    end else begin
                        state_d      = StServeI;
                        last_grant_d = GrantI;
                    end
                end else if (i_req) begin
                    state_d      = StServeI;
                    last_grant_d = GrantI;
                end else if (d_req) begin
                    state_d      = StServeD;
                    last_grant_d = GrantD;
                end
            end

            StServeI: begin
                arb_busy         = 1'b1;
                // Strobe follows the live input even if the requester drops early.
                pmem_read        = icache_pmem_read;
                pmem_address     = icache_pmem_address & LineMask;
                icache_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d = StIdle;
                end
            end

            StServeD: begin
                arb_busy         = 1'b1;
                // Read and write together is treated as a write-back.
                pmem_write       = dcache_pmem_write;
                pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
                pmem_address     = dcache_pmem_address & LineMask;
                pmem_wdata       = dcache_pmem_wdata;
                dcache_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
